// File: rtl/result_uart_tx.sv
// -----------------------------------------------------------------------------
// result_uart_tx
//   Captures result words strobed out by the datapath, buffers them in a small
//   FIFO and serialises each word as one or more 8-bit UART frames on tx,
//   most-significant byte first, LSB first within a byte.
//
// Parameters
//   clk_freq  system clock frequency in Hz
//   baud      line rate; one bit time is DIV = clk_freq/baud cycles (>= 2)
//   WIDTH     result word width, a multiple of 8
//   DEPTH     FIFO entries, a power of 2, >= 2
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   data_in     result word from the datapath
//   data_valid  write strobe, one word per high cycle
//   tx          UART line, idle high, registered
//   busy        a frame is on the line or the FIFO is non-empty
//   full        FIFO holds DEPTH words
//   overrun     one-cycle pulse the cycle after a write was dropped
//
// Configuration
//   UART_PARITY_EN  when defined, an even parity bit follows the data bits
//                   (8E1 frames); otherwise frames are 8N1.
// -----------------------------------------------------------------------------
module result_uart_tx #(
    parameter int clk_freq = 50000000,
    parameter int baud     = 115200,
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             tx,
    output logic             busy,
    output logic             full,
    output logic             overrun
);

    localparam int DIV   = clk_freq / baud;
    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int BI_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [BI_W-1:0]  BYTE_LAST = BI_W'(BYTES - 1);
    localparam logic [PTR_W:0]   FIFO_MAX  = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_n;
    logic [2:0]       bit_idx, bit_n;
    logic [BI_W-1:0]  byte_idx, byte_n;
    logic [WIDTH-1:0] shift, shift_n;
    logic [7:0]       cur_byte;
    logic             baud_done;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_n;
    logic             push, pop;
    logic             tx_n, busy_n;

    assign baud_done = (baud_cnt == BAUD_LAST);
    assign full      = (count == FIFO_MAX);

    // Next-state logic. tx and busy are computed from the *next* state so that
    // their registers line up with the state register: the pop cycle is
    // followed directly by tx=0.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        byte_n   = byte_idx;
        shift_n  = shift;
        pop      = 1'b0;
        push     = 1'b0;
        count_n  = count;
        tx_n     = 1'b1;
        busy_n   = 1'b0;
        cur_byte = '0;

        if (state != IDLE) begin
            baud_n = baud_done ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    byte_n  = '0;
                    baud_n  = '0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_done) begin
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_n = PAR;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            PAR: begin
                if (baud_done) state_n = STOP;
            end
`endif
            STOP: begin
                if (baud_done) begin
                    if (byte_idx != BYTE_LAST) begin
                        // Next byte of the same word follows with no gap;
                        // shifting keeps the active byte at the top.
                        byte_n  = byte_idx + BI_W'(1);
                        shift_n = shift << 8;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A full FIFO still accepts a word when the head leaves this cycle.
        push = data_valid && ((count != FIFO_MAX) || pop);

        case ({push, pop})
            2'b10:   count_n = count + (PTR_W + 1)'(1);
            2'b01:   count_n = count - (PTR_W + 1)'(1);
            default: count_n = count;
        endcase

        cur_byte = shift_n[WIDTH-1 -: 8];
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_n];
`ifdef UART_PARITY_EN
            PAR:     tx_n = ^cur_byte;
`endif
            default: tx_n = 1'b1;
        endcase

        busy_n = (state_n != IDLE) || (count_n != '0);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge.
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shift    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            shift    <= shift_n;
            count    <= count_n;
            tx       <= tx_n;
            busy     <= busy_n;
            overrun  <= data_valid && !push;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: the storage array has no reset; count and pointers define which
    // entries are valid, so stale contents are never read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_result_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_result_uart_tx
//   Randomised scoreboard bench for result_uart_tx (clk_freq=1000, baud=100,
//   so one bit time is 10 cycles; WIDTH=16, DEPTH=4). The stimulus side keeps a
//   word-level model of the FIFO and the line (a word leaves the queue when the
//   line is free and occupies it for one pop cycle plus BYTES frames) and
//   pushes the expected frames into a queue. An independent monitor decodes
//   the tx line every cycle and compares it, plus busy/full/overrun.
//   Honours UART_PARITY_EN like the design.
// -----------------------------------------------------------------------------
module tb_result_uart_tx;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int WIDTH    = 16;
    localparam int DEPTH    = 4;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int BYTES    = WIDTH / 8;
`ifdef UART_PARITY_EN
    localparam int FBITS    = 11;
`else
    localparam int FBITS    = 10;
`endif
    localparam int FRAME    = FBITS * DIV;
    localparam int SERVICE  = 1 + BYTES * FRAME;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] data_in = '0;
    logic             data_valid = 1'b0;
    logic             tx, busy, full, overrun;

    result_uart_tx #(
        .clk_freq(CLK_FREQ),
        .baud    (BAUD),
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .data_valid(data_valid),
        .tx        (tx),
        .busy      (busy),
        .full      (full),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        int         start;
    } frame_t;

    frame_t           exp_q[$];
    logic [WIDTH-1:0] model_fifo[$];
    int               line_free     = 0;
    bit               drop_prev     = 1'b0;
    bit               reset_pending = 1'b0;
    bit               exp_full      = 1'b0;
    bit               exp_busy      = 1'b0;
    bit               exp_overrun   = 1'b0;
    bit               mon_en        = 1'b0;
    bit               mon_active    = 1'b0;

    // Line level of bit slot i of a frame carrying byte b.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_PARITY_EN
        if (i == 9) return ($countones(b) % 2) == 1;
`endif
        return 1'b1;
    endfunction

    // Monitor: decodes tx and compares flags against the model's expectations.
    frame_t cur;
    int     mon_start;
    int     o;
    always @(negedge clk) begin
        if (mon_en) begin
            check("full", full, exp_full);
            check("busy", busy, exp_busy);
            check("overrun", overrun, exp_overrun);
            if (rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx !== 1'b1) begin
                    check("frame_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        cur        = exp_q.pop_front();
                        mon_active = 1'b1;
                        mon_start  = cyc;
                        check("frame_start_cycle", cyc, cur.start);
                    end
                end
                if (mon_active) begin
                    o = cyc - mon_start;
                    check("tx_bit", tx, frame_bit(cur.b, o / DIV));
                    if (o == FRAME - 1) mon_active = 1'b0;
                end
            end
        end
    end

    // One stimulus cycle: advance the model, publish expectations, drive inputs.
    task automatic step(input bit dv, input logic [WIDTH-1:0] d, input bit r);
        int               c;
        bit               pop, acc;
        logic [WIDTH-1:0] w, t;
        @(posedge clk);
        #1;
        if (reset_pending) begin
            model_fifo.delete();
            exp_q.delete();
            line_free     = 0;
            drop_prev     = 1'b0;
            reset_pending = 1'b0;
        end
        c           = cyc;
        exp_overrun = drop_prev;
        exp_full    = (model_fifo.size() == DEPTH);
        exp_busy    = (model_fifo.size() > 0) || (c < line_free);
        pop         = (model_fifo.size() > 0) && (c >= line_free);
        if (pop) begin
            w = model_fifo.pop_front();
            for (int k = 0; k < BYTES; k++) begin
                t = w >> (8 * (BYTES - 1 - k));
                exp_q.push_back('{b: t[7:0], start: c + 1 + k * FRAME});
            end
            line_free = c + SERVICE;
        end
        acc = dv && (model_fifo.size() < DEPTH);
        if (acc) model_fifo.push_back(d);
        drop_prev  = dv && !acc;
        data_valid = dv;
        data_in    = d;
        rst        = r;
        if (r) reset_pending = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (model_fifo.size() > 0 || cyc < line_free); i++)
            step(1'b0, '0, 1'b0);
        idle(3);
        check("drained_frames_left", exp_q.size(), 0);
    endtask

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and reset-state checks.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        check("reset_tx", tx, 1);
        idle(5);

        // Single two-byte word: 0xA1 then 0xB2 back to back.
        step(1'b1, 16'hA1B2, 1'b0);
        drain();

        // Parity-sensitive word.
        step(1'b1, 16'h0007, 1'b0);
        drain();

        // Burst of six: fifth fills the FIFO, sixth is dropped.
        for (int i = 1; i <= 6; i++) step(1'b1, WIDTH'(i), 1'b0);
        drain();

        // Reset in the middle of the first frame with words still queued.
        for (int i = 0; i < 3; i++) step(1'b1, WIDTH'($urandom), 1'b0);
        idle(41);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        @(negedge clk);
        check("post_reset_tx", tx, 1);
        check("post_reset_busy", busy, 0);
        check("post_reset_full", full, 0);
        idle(300);

        // data_valid held high: drops while full, acceptance on pop cycles.
        for (int i = 0; i < 450; i++) step(1'b1, WIDTH'($urandom), 1'b0);
        drain();

        // Sparse random traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 79) == 0, WIDTH'($urandom), 1'b0);
        drain();

        check("monitor_idle_at_end", mon_active, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
